acc_cmd_sequencer: RTL and testbench



---
 rtl/acc_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_acc_cmd_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_cmd_sequencer.sv
// Button front-end and command sequencer for the Basys2 adder/accumulator datapath.
// Build macro AUTO_REPEAT_EN adds periodic synthetic add events while the add button is held.
module acc_cmd_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned ACK_TIMEOUT     = 16,
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned REPEAT_CYCLES   = 32
) (
   input  logic             MCLK,
   input  logic             rst_n,
   input  logic             btn_clear,
   input  logic             btn_load,
   input  logic             btn_add,
   input  logic [7:0]       sw,
   output logic             reg1_we,
   output logic [7:0]       reg1_data,
   output logic             acc_add,
   output logic             acc_clr,
   input  logic             acc_ack,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output logic             timeout_err
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255 ||
       CNT_W < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("acc_cmd_sequencer: parameter out of range");
   end

   typedef enum logic [2:0] {StIdle, StClear, StLoad, StAddReq, StAddWait} state_e;

   // Button bit order: 0 = clear, 1 = load, 2 = add.
   logic [2:0] sync1_q, sync2_q, deb_q, deb_prev_q, press;
   logic [7:0] dcnt_q [3];
   logic       clr_ev, load_ev, add_ev;

   state_e           state_q, state_d;
   logic [7:0]       tmr_q, tmr_d;
   logic [7:0]       reg1_data_q, reg1_data_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge MCLK) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      end else begin
         sync1_q    <= {btn_add, btn_load, btn_clear};
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               dcnt_q[i] <= '0;
            end else if (dcnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
               deb_q[i]  <= sync2_q[i];
               dcnt_q[i] <= '0;
            end else begin
               dcnt_q[i] <= dcnt_q[i] + 8'd1;
            end
         end
      end
   end

   assign press   = deb_q & ~deb_prev_q;
   assign clr_ev  = press[0];
   assign load_ev = press[1];

`ifdef AUTO_REPEAT_EN
   logic        rep_on_q;
   logic [31:0] rep_cnt_q;
   logic        rep_fire;

   assign rep_fire = rep_on_q && (rep_cnt_q == 32'(REPEAT_CYCLES - 1));

   // Interval restarts on every fire, whether or not the FSM accepts the event.
   always_ff @(posedge MCLK) begin
      if (!rst_n) begin
         rep_on_q  <= 1'b0;
         rep_cnt_q <= '0;
      end else if (clr_ev || !deb_q[2]) begin
         rep_on_q  <= 1'b0;
         rep_cnt_q <= '0;
      end else if (press[2]) begin
         rep_on_q  <= 1'b1;
         rep_cnt_q <= '0;
      end else if (rep_on_q) begin
         rep_cnt_q <= rep_fire ? '0 : rep_cnt_q + 32'd1;
      end
   end

   assign add_ev = press[2] || rep_fire;
`else
   assign add_ev = press[2];
`endif

   always_ff @(posedge MCLK) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         tmr_q       <= '0;
         reg1_data_q <= '0;
         op_count_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         reg1_data_q <= reg1_data_d;
         op_count_q  <= op_count_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      reg1_data_d = reg1_data_q;
      op_count_d  = op_count_q;
      timeout_d   = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (clr_ev) begin
               state_d = StClear;
            end else if (load_ev) begin
               state_d     = StLoad;
               reg1_data_d = sw;
            end else if (add_ev) begin
               state_d = StAddReq;
            end
         end
         StClear: begin
            op_count_d = '0;
            timeout_d  = 1'b0;
            state_d    = StIdle;
         end
         StLoad: state_d = StIdle;
         StAddReq: begin
            tmr_d   = '0;
            state_d = StAddWait;
         end
         StAddWait: begin
            if (acc_ack) begin
               if (op_count_q != '1) op_count_d = op_count_q + CNT_W'(1);
               state_d = StIdle;
            end else if (tmr_q == 8'(ACK_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = StIdle;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      // Clear aborts whatever is in flight.
      if (state_q != StIdle && clr_ev) state_d = StClear;
   end

   // Strobes are masked while reset is asserted so none escapes on the reset cycle.
   assign reg1_we     = rst_n && (state_q == StLoad);
   assign acc_add     = rst_n && (state_q == StAddReq);
   assign acc_clr     = rst_n && (state_q == StClear);
   assign busy        = (state_q != StIdle);
   assign reg1_data   = reg1_data_q;
   assign op_count    = op_count_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_acc_cmd_sequencer.sv
// Directed self-checking bench for acc_cmd_sequencer (default parameters).
// The held-add step expects repeated adds when AUTO_REPEAT_EN is defined.
module tb_acc_cmd_sequencer;

   logic        MCLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_clear = 1'b0, btn_load = 1'b0, btn_add = 1'b0;
   logic [7:0]  sw = 8'h00;
   logic        reg1_we, acc_add, acc_clr, busy, timeout_err;
   logic        acc_ack = 1'b0;
   logic [7:0]  reg1_data;
   logic [15:0] op_count;

   int checks = 0, errors = 0;
   int cyc = 0;
   int n_add = 0, n_clr = 0, n_we = 0, n_busy = 0, n_multi = 0, n_ack = 0;
   int we_cyc = 0, clr_cyc = 0;
   logic [7:0] last_data = 8'h00;
   int ack_delay = 0, cd = 0;

   acc_cmd_sequencer dut (
      .MCLK(MCLK), .rst_n(rst_n), .btn_clear(btn_clear), .btn_load(btn_load),
      .btn_add(btn_add), .sw(sw), .reg1_we(reg1_we), .reg1_data(reg1_data),
      .acc_add(acc_add), .acc_clr(acc_clr), .acc_ack(acc_ack), .busy(busy),
      .op_count(op_count), .timeout_err(timeout_err)
   );

   always #5 MCLK = ~MCLK;

   always @(posedge MCLK) cyc++;

   // Pulse monitors and acknowledging accumulator model, sampled mid-cycle.
   always @(negedge MCLK) begin
      if (acc_add) n_add++;
      if (acc_clr) begin n_clr++; clr_cyc = cyc; end
      if (reg1_we) begin n_we++; we_cyc = cyc; last_data = reg1_data; end
      if (busy) n_busy++;
      if (int'(reg1_we) + int'(acc_add) + int'(acc_clr) > 1) n_multi++;
      acc_ack = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin acc_ack = 1'b1; n_ack++; end
      end
      if (acc_add && ack_delay > 0) cd = ack_delay;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge MCLK);
         #1;
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_clear = v;
         1: btn_load = v;
         default: btn_add = v;
      endcase
   endtask

   task automatic press(input int b, input int hi, input int lo);
      set_btn(b, 1'b1);
      step(hi);
      set_btn(b, 1'b0);
      step(lo);
   endtask

   task automatic wait_add(input string tag, output int a_cyc);
      int k;
      k = 0;
      while (!acc_add && k < 30) begin step(); k++; end
      a_cyc = cyc;
      chk(tag, {31'd0, acc_add}, 32'd1);
   endtask

   int b_add, b_clr, b_we, b_busy, b_ack, p, a;

   initial begin
      step(3);
      chk("rst_reg1_we", {31'd0, reg1_we}, 32'd0);
      chk("rst_acc_add", {31'd0, acc_add}, 32'd0);
      chk("rst_acc_clr", {31'd0, acc_clr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_op_count", {16'd0, op_count}, 32'd0);
      chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
      chk("rst_reg1_data", {24'd0, reg1_data}, 32'd0);
      rst_n = 1'b1;
      step(2);

      // Load: one write strobe 7 cycles after the raw press.
      sw = 8'h02;
      b_we = n_we;
      p = cyc;
      press(1, 10, 10);
      sw = 8'h5A;
      chk("load_count", n_we - b_we, 1);
      chk("load_data", {24'd0, last_data}, 32'h02);
      chk("load_latency", we_cyc - p, 7);
      chk("load_hold", {24'd0, reg1_data}, 32'h02);
      chk("load_op_count", {16'd0, op_count}, 32'd0);

      // Single add acked 3 cycles later.
      ack_delay = 3;
      b_add = n_add; b_busy = n_busy;
      press(2, 10, 10);
      chk("add_count", n_add - b_add, 1);
      chk("add_op_count", {16'd0, op_count}, 32'd1);
      chk("add_busy_cycles", n_busy - b_busy, 4);
      chk("add_timeout", {31'd0, timeout_err}, 32'd0);

      // Short glitches are filtered.
      b_add = n_add;
      for (int i = 0; i < 3; i++) press(2, 2, 8);
      chk("glitch_no_add", n_add - b_add, 0);

      // 300 clean presses with immediate ack.
      ack_delay = 1;
      b_add = n_add;
      for (int i = 0; i < 300; i++) press(2, 10, 10);
      chk("many_add_count", n_add - b_add, 300);
      chk("many_op_count", {16'd0, op_count}, 32'd301);

      // No ack: abort after ADD_REQ + 16 wait cycles.
      ack_delay = 0;
      b_busy = n_busy;
      press(2, 10, 30);
      chk("to_busy_cycles", n_busy - b_busy, 17);
      chk("to_flag", {31'd0, timeout_err}, 32'd1);
      chk("to_op_count", {16'd0, op_count}, 32'd301);

      b_clr = n_clr;
      press(0, 10, 10);
      chk("clr_count", n_clr - b_clr, 1);
      chk("clr_timeout", {31'd0, timeout_err}, 32'd0);
      chk("clr_op_count", {16'd0, op_count}, 32'd0);

      // Clear and add together: clear wins, add dropped.
      b_clr = n_clr; b_add = n_add;
      btn_clear = 1'b1; btn_add = 1'b1;
      step(10);
      btn_clear = 1'b0; btn_add = 1'b0;
      step(10);
      chk("both_clr", n_clr - b_clr, 1);
      chk("both_add", n_add - b_add, 0);

      ack_delay = 3;
      press(2, 10, 10);
      chk("pre_abort_op", {16'd0, op_count}, 32'd1);

      // Clear during ADD_WAIT; the late ack must be ignored.
      ack_delay = 10;
      b_ack = n_ack; b_add = n_add;
      btn_add = 1'b1;
      wait_add("abort_add_seen", a);
      btn_clear = 1'b1;
      step(14);
      btn_add = 1'b0; btn_clear = 1'b0;
      step(10);
      chk("abort_clr_time", clr_cyc - a, 7);
      chk("abort_late_ack", n_ack - b_ack, 1);
      chk("abort_add_count", n_add - b_add, 1);
      chk("abort_op_count", {16'd0, op_count}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);

      // Load event while an add waits is dropped.
      ack_delay = 0;
      b_we = n_we;
      press(2, 10, 0);
      press(1, 10, 30);
      chk("busy_load_drop", n_we - b_we, 0);
      chk("busy_to_flag", {31'd0, timeout_err}, 32'd1);
      press(0, 10, 10);

      // Held add button.
      ack_delay = 1;
      b_add = n_add;
      press(2, 100, 20);
`ifdef AUTO_REPEAT_EN
      chk("hold_add_count", n_add - b_add, 4);
      chk("hold_op_count", {16'd0, op_count}, 32'd4);
`else
      chk("hold_add_count", n_add - b_add, 1);
      chk("hold_op_count", {16'd0, op_count}, 32'd1);
`endif

      // Reset in the middle of an add.
      ack_delay = 0;
      btn_add = 1'b1;
      wait_add("rst_add_seen", a);
      btn_add = 1'b0;
      step(2);
      b_add = n_add; b_clr = n_clr; b_we = n_we;
      rst_n = 1'b0;
      #3;
      chk("midrst_no_strobe", {29'd0, reg1_we, acc_add, acc_clr}, 32'd0);
      step(2);
      rst_n = 1'b1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_op_count", {16'd0, op_count}, 32'd0);
      step(30);
      chk("midrst_strobes", (n_add - b_add) + (n_clr - b_clr) + (n_we - b_we), 0);
      chk("midrst_timeout", {31'd0, timeout_err}, 32'd0);

      chk("strobe_exclusive", n_multi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
